// File: rtl/debounce_pkg.sv
// Shared defaults and sizing helper for the push-button debouncer.
package debounce_pkg;

  localparam int unsigned STABLE_CYCLES_DEF = 2000000;
  localparam int unsigned SYNC_STAGES_DEF   = 2;

  // Counter must reach STABLE_CYCLES-1 and never wrap; keep at least 1 bit.
  function automatic int unsigned cnt_width(input int unsigned stable_cycles);
    return (stable_cycles <= 2) ? 1 : $clog2(stable_cycles);
  endfunction

  localparam int unsigned CNT_W_DEF = cnt_width(STABLE_CYCLES_DEF);

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_ff
  import debounce_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_p0;

  always_ff @(posedge clk) begin
    if (rst) ff_p0 <= '0;
    else     ff_p0 <= {ff_p0[STAGES-2:0], d};
  end

  assign q = ff_p0[STAGES-1];

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer: synchronizes key_i, accepts a new level only after
// it has persisted STABLE_CYCLES cycles, and flags each accepted edge.
module key_debounce
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic key_o,
  output logic key_rise,
  output logic key_fall
);

  localparam int unsigned        CNT_W   = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic             key_s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             accept;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_i),
    .q   (key_s)
  );

  // Any cycle where the synchronized level matches key_o restarts the count.
  always_comb begin
    cnt_nxt = '0;
    accept  = 1'b0;
    if (key_s != key_o) begin
      if (cnt == CNT_MAX) accept  = 1'b1;
      else                cnt_nxt = cnt + 1'b1;
    end
  end

  // Filter state and registered edge flags
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      key_o    <= 1'b0;
      key_rise <= 1'b0;
      key_fall <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      key_rise <= accept &  key_s;
      key_fall <= accept & ~key_s;
      if (accept) key_o <= key_s;
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce with STABLE_CYCLES=8, SYNC_STAGES=2.
module tb_key_debounce;

  localparam int SC   = 8;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst;
  logic key_i;
  logic key_o;
  logic key_rise;
  logic key_fall;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Reference: delay line for the synchronizer plus a history of levels seen.
  logic sync_q [SYNC];
  logic hist [$];
  logic m_o, m_rise, m_fall;
  logic prev_pulse;

  int rise_cnt, fall_cnt, last_rise_edge, last_fall_edge;

  key_debounce #(
    .STABLE_CYCLES (SC),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_i    (key_i),
    .key_o    (key_o),
    .key_rise (key_rise),
    .key_fall (key_fall)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, act, exp);
    end
  endtask

  // A new level is accepted once the last SC observed levels all differ from key_o.
  task automatic model_step(input logic k, input logic r);
    logic ks;
    bit   all_diff;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (r) begin
      for (int i = 0; i < SYNC; i++) sync_q[i] = 1'b0;
      hist.delete();
      m_o = 1'b0;
    end else begin
      ks = sync_q[SYNC-1];
      hist.push_back(ks);
      if (hist.size() > SC) void'(hist.pop_front());
      all_diff = (hist.size() == SC);
      foreach (hist[i]) if (hist[i] == m_o) all_diff = 0;
      if (all_diff) begin
        m_o    = ~m_o;
        m_rise = m_o;
        m_fall = ~m_o;
      end
      for (int i = SYNC - 1; i > 0; i--) sync_q[i] = sync_q[i-1];
      sync_q[0] = k;
    end
  endtask

  task automatic compare();
    check("key_o", key_o, m_o);
    check("key_rise", key_rise, m_rise);
    check("key_fall", key_fall, m_fall);
    check("pulse_exclusive", int'(key_rise & key_fall), 0);
    check("pulse_back_to_back", int'(prev_pulse & (key_rise | key_fall)), 0);
    prev_pulse = key_rise | key_fall;
    if (key_rise === 1'b1) begin rise_cnt++; last_rise_edge = edge_n; end
    if (key_fall === 1'b1) begin fall_cnt++; last_fall_edge = edge_n; end
  endtask

  task automatic tick(input logic k, input logic r);
    key_i = k;
    rst   = r;
    @(posedge clk);
    edge_n++;
    model_step(k, r);
    #1;
    compare();
  endtask

  task automatic clear_stats();
    rise_cnt = 0; fall_cnt = 0;
    last_rise_edge = -1; last_fall_edge = -1;
  endtask

  task automatic hold(input logic k, input int n);
    for (int i = 0; i < n; i++) tick(k, 1'b0);
  endtask

  initial begin
    int start;
    logic lvl;
    int   run;
    key_i = 1'b0;
    rst   = 1'b1;
    prev_pulse = 1'b0;
    m_o = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
    for (int i = 0; i < SYNC; i++) sync_q[i] = 1'b0;
    clear_stats();
    #2;

    // Reset with key_i high: outputs must stay low throughout.
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1);
      check("reset_key_o", key_o, 0);
      check("reset_pulses", int'(key_rise | key_fall), 0);
    end
    hold(1'b0, 12);

    // Clean press.
    clear_stats();
    start = edge_n;
    hold(1'b1, 20);
    check("press_latency", last_rise_edge - start, 10);
    check("press_rise_count", rise_cnt, 1);
    check("press_fall_count", fall_cnt, 0);

    // Release.
    clear_stats();
    start = edge_n;
    hold(1'b0, 20);
    check("release_latency", last_fall_edge - start, 10);
    check("release_fall_count", fall_cnt, 1);
    check("release_rise_count", rise_cnt, 0);

    // Bounce before settling high.
    clear_stats();
    hold(1'b1, 3); hold(1'b0, 3); hold(1'b1, 3); hold(1'b0, 3);
    start = edge_n;
    hold(1'b1, 20);
    check("bounce_latency", last_rise_edge - start, 10);
    check("bounce_rise_count", rise_cnt, 1);
    check("bounce_fall_count", fall_cnt, 0);

    // Short glitch from a low key_o.
    hold(1'b0, 20);
    clear_stats();
    hold(1'b1, 7);
    hold(1'b0, 20);
    check("glitch_key_o", key_o, 0);
    check("glitch_pulses", rise_cnt + fall_cnt, 0);

    // Mid-count reset at edge 6.
    clear_stats();
    hold(1'b1, 5);
    tick(1'b1, 1'b1);
    check("midrst_key_o", key_o, 0);
    start = edge_n;
    hold(1'b1, 20);
    check("midrst_latency", last_rise_edge - start, 10);
    check("midrst_rise_count", rise_cnt, 1);

    // Randomized runs with occasional resets.
    hold(1'b0, 20);
    lvl = 1'b0;
    for (int n = 0; n < 400; n++) begin
      lvl = ($urandom_range(0, 3) != 0) ? ~lvl : lvl;
      run = $urandom_range(1, 14);
      for (int i = 0; i < run; i++)
        tick(lvl, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter STABLE_CYCLES, default 2000000 (20 ms at 100 MHz); number of consecutive clk cycles a new synchronized level must persist before it is accepted; legal range 2..2^24.
REQ-002 Parameter SYNC_STAGES, default 2; flip-flop stages in the input synchronizer; legal range 2..4.
REQ-003 clk  input  1  system clock; all logic is on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 key_i  input  1  raw mechanical push-button level, asynchronous to clk, bouncing.
REQ-006 key_o  output  1  debounced level; clean enough to drive a downstream clock or enable.
REQ-007 key_rise  output  1  one-cycle pulse in the cycle key_o goes 0->1.
REQ-008 key_fall  output  1  one-cycle pulse in the cycle key_o goes 1->0.

Function
REQ-009 key_i SHALL pass through a SYNC_STAGES-deep flip-flop chain; only the last stage (key_s) feeds the filter.
REQ-010 Counter cnt, width $clog2(STABLE_CYCLES), unsigned; SHALL clear to 0 on any cycle where key_s == key_o.
REQ-011 When key_s != key_o and cnt < STABLE_CYCLES-1, cnt SHALL increment by 1.
REQ-012 When key_s != key_o and cnt == STABLE_CYCLES-1, key_o SHALL take key_s, cnt SHALL clear to 0, and exactly one of key_rise/key_fall SHALL assert for that one cycle.
REQ-013 cnt SHALL never wrap; it never exceeds STABLE_CYCLES-1.
REQ-014 Latency: a clean step on key_i SHALL change key_o at rising edge SYNC_STAGES+STABLE_CYCLES, counting the first edge that samples the new level as edge 1 (edge 10 for 2/8).
REQ-015 Any glitch or bounce on key_s that returns to key_o before acceptance SHALL restart the count from 0; key_o SHALL NOT change.
REQ-016 key_rise and key_fall SHALL be registered, mutually exclusive, and never asserted in consecutive cycles.
REQ-017 key_o SHALL be driven directly from a flip-flop, with no combinational path from key_i.
REQ-018 A held level SHALL produce no further pulses.

Reset
REQ-019 While rst is high at a clk edge: all synchronizer stages, key_o, key_rise, key_fall and cnt SHALL load 0.
REQ-020 rst asserted mid-count SHALL discard the partial count; after release, key_i held at 1 SHALL raise key_o only after the full latency of REQ-014.
REQ-021 rst SHALL take priority over every other update in the same cycle.

Structure
REQ-022 Shared package debounce_pkg SHALL hold the STABLE_CYCLES and SYNC_STAGES defaults and a helper constant for the counter width.
REQ-023 The synchronizer SHALL be one sub-module, sync_ff (parameter STAGES, ports clk, rst, d, q), instantiated once.
REQ-024 The filter counter and output registers SHALL live in key_debounce itself.

Verification (benches use STABLE_CYCLES=8, SYNC_STAGES=2)
REQ-025 Reset: rst=1 for 3 cycles with key_i=1 -> key_o=0, key_rise=0, key_fall=0 throughout.
REQ-026 Clean press: key_i 0->1 held 20 cycles -> key_o=1 at edge 10 with key_rise=1 for exactly that cycle, no key_fall.
REQ-027 Bounce: key_i toggles 1,0,1,0 every 3 cycles then holds 1 -> key_o stays 0 until 10 edges after the final 0->1, then one key_rise.
REQ-028 Short glitch: key_i=1 for 7 cycles, then 0 -> key_o never rises, no pulses.
REQ-029 Release: from key_o=1, key_i 1->0 held -> key_o=0 at edge 10 with a single key_fall.
REQ-030 Mid-count reset: key_i=1, rst pulsed for 1 cycle at edge 6 -> key_o stays 0 until 10 edges after rst deasserts.
